// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: pipeline sequencer state
// encoding, HALT opcode and default register-address width.
package mips_pkg;

    localparam int unsigned REG_AW_DEF      = 5;
    localparam logic [5:0]  HALT_OPCODE_DEF = 6'b111111;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_STEP_WAIT = 3'd1,
        ST_STEP_EXEC = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_HALTED    = 3'd4
    } state_e;

    function automatic logic is_halt(input logic [5:0] opcode, input logic [5:0] halt_opcode);
        return opcode == halt_opcode;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// read by the instruction in ID. Register 0 never creates a hazard.
module load_use_detect #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    output logic              load_use_o
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit     = (ex_rt_i == id_rs_i);
        rt_hit     = id_uses_rt_i && (ex_rt_i == id_rt_i);
        load_use_o = ex_mem_read_i && (ex_rt_i != '0) && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, branch flush, HALT drain and debug
// single-step. Optional performance counters under PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned REG_AW       = mips_pkg::REG_AW_DEF,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [5:0]  HALT_OPCODE  = mips_pkg::HALT_OPCODE_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [5:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_memRead,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              branch_taken,
    input  logic              step_mode,
    input  logic              step_req,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              flush_ifid,
    output logic              stall_idex,
    output logic              flush_idex,
    output logic              freeze,
    output logic              halted,
    output logic [2:0]        state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam int unsigned CW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic load_use;
    logic halt_id;
    logic halt_eff;
    logic active;
    logic stall_pc_c, stall_ifid_c, flush_ifid_c, stall_idex_c, flush_idex_c;
    logic freeze_c, halted_c;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ex_mem_read_i (ex_memRead),
        .ex_rt_i       (ex_rt),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .load_use_o    (load_use)
    );

    // A HALT only takes effect when neither a branch squashes it nor a
    // load-use stall keeps it waiting in ID.
    always_comb begin
        halt_id  = is_halt(id_opcode, HALT_OPCODE);
        active   = (state_q == ST_RUN) || (state_q == ST_STEP_EXEC);
        halt_eff = active && halt_id && !branch_taken && !load_use;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_pc_c   = 1'b0;
        stall_ifid_c = 1'b0;
        flush_ifid_c = 1'b0;
        stall_idex_c = 1'b0;
        flush_idex_c = 1'b0;
        freeze_c     = 1'b0;
        halted_c     = 1'b0;
        unique case (state_q)
            ST_RUN, ST_STEP_EXEC: begin
                if (branch_taken) begin
                    flush_ifid_c = 1'b1;
                    flush_idex_c = 1'b1;
                end else if (load_use) begin
                    stall_pc_c   = 1'b1;
                    stall_ifid_c = 1'b1;
                    flush_idex_c = 1'b1;
                end else if (halt_id) begin
                    stall_pc_c   = 1'b1;
                    flush_ifid_c = 1'b1;
                    flush_idex_c = 1'b1;
                end
                if (halt_eff) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CW'(DRAIN_CYCLES - 1);
                end else if (step_mode) begin
                    state_d = ST_STEP_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP_WAIT: begin
                stall_pc_c   = 1'b1;
                stall_ifid_c = 1'b1;
                stall_idex_c = 1'b1;
                freeze_c     = 1'b1;
                if (step_req) begin
                    state_d = ST_STEP_EXEC;
                end else if (!step_mode) begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                stall_pc_c   = 1'b1;
                flush_ifid_c = 1'b1;
                flush_idex_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HALTED: begin
                stall_pc_c   = 1'b1;
                stall_ifid_c = 1'b1;
                stall_idex_c = 1'b1;
                freeze_c     = 1'b1;
                halted_c     = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are forced to their reset values while reset is held, even if
    // the hazard inputs would otherwise assert a stall or flush.
    always_comb begin
        stall_pc   = stall_pc_c   & ~reset;
        stall_ifid = stall_ifid_c & ~reset;
        flush_ifid = flush_ifid_c & ~reset;
        stall_idex = stall_idex_c & ~reset;
        flush_idex = flush_idex_c & ~reset;
        freeze     = freeze_c     & ~reset;
        halted     = halted_c     & ~reset;
        state      = state_q;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_q != ST_HALTED) && !freeze_c) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
            if (active && !branch_taken && load_use) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (active && branch_taken) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        cycle_cnt = cycle_cnt_q;
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end
`endif

endmodule
